// File: rtl/obstacle_manager.sv
// Obstacle manager for an endless-runner game. It spawns obstacles into a
// small set of slots, moves them toward the dino once per game tick, ramps
// the scroll speed, and detects a collision with the dino.
module obstacle_manager #(
   parameter int          NUM_SLOTS  = 3,
   parameter int          POS_W      = 10,
   parameter int          TYPE_W     = 3,
   parameter int          NUM_TYPES  = 5,
   parameter int          SPAWN_X    = 640,
   parameter int          DINO_X     = 64,
   parameter int          DINO_W     = 40,
   parameter int          HIT_H      = 48,
   parameter int          MIN_GAP    = 40,
   parameter int          GAP_MASK   = 15,
   parameter int          SPEED_INIT = 4,
   parameter int          SPEED_MAX  = 12,
   parameter int          SPEED_STEP = 256,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tick,
   input  logic                        start,
   input  logic [POS_W-1:0]            dino_h,
   output logic [NUM_SLOTS*POS_W-1:0]  danger_pos,
   output logic [NUM_SLOTS*TYPE_W-1:0] danger_type,
   output logic [NUM_SLOTS-1:0]        danger_en,
   output logic [1:0]                  game_state,
   output logic [3:0]                  speed,
   output logic                        hit
);

   localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   state_t                           state_q, state_d;
   logic [NUM_SLOTS-1:0][POS_W-1:0]  pos_q, pos_d;
   logic [NUM_SLOTS-1:0][TYPE_W-1:0] type_q, type_d;
   logic [NUM_SLOTS-1:0]             en_q, en_d;
   logic [7:0]                       gap_q, gap_d;
   logic [STEP_W-1:0]                step_q, step_d;
   logic [3:0]                       speed_q, speed_d;
   logic [15:0]                      lfsr_q, lfsr_d;
   logic                             hit_q, hit_d;

   logic [NUM_SLOTS-1:0] free_first;  // one-hot: lowest slot free before this tick
   logic [NUM_SLOTS-1:0] spawn_sel;
   logic [NUM_SLOTS-1:0] in_window;
   logic                 spawn_due;
   logic                 collide;
   logic                 lfsr_fb;
   logic [POS_W-1:0]     speed_px;
   logic [TYPE_W-1:0]    spawn_type;

   // Spawn decision, collision window and LFSR feedback from registered state.
   always_comb begin
      free_first = ~en_q & (en_q + NUM_SLOTS'(1));
      spawn_due  = ({24'd0, gap_q} >=
                    32'(MIN_GAP) + {24'd0, lfsr_q[7:0] & 8'(GAP_MASK)});
      spawn_sel  = spawn_due ? free_first : '0;
      spawn_type = TYPE_W'(lfsr_q[15:8] % 8'(NUM_TYPES));
      speed_px   = POS_W'(speed_q);
      lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      in_window  = '0;
      // Widen by one bit so pos + 8 cannot wrap near the top of the range.
      for (int i = 0; i < NUM_SLOTS; i++) begin
         in_window[i] = en_q[i] &&
            (({1'b0, pos_q[i]} + (POS_W+1)'(8)) >= (POS_W+1)'(DINO_X)) &&
            ({1'b0, pos_q[i]} < (POS_W+1)'(DINO_X + DINO_W));
      end
      collide = (state_q == ST_RUN) && (|in_window) && (dino_h < POS_W'(HIT_H));
   end

   // Next-state logic for the game FSM, slots, gap/step counters, speed and LFSR.
   always_comb begin
      // NOTE: every _d starts from its _q so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      pos_d   = pos_q;
      type_d  = type_q;
      en_d    = en_q;
      gap_d   = gap_q;
      step_d  = step_q;
      speed_d = speed_q;
      lfsr_d  = lfsr_q;
      hit_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            pos_d  = '0;
            type_d = '0;
            en_d   = '0;
            if (start) begin
               state_d = ST_RUN;
               gap_d   = '0;
               step_d  = '0;
               speed_d = 4'(SPEED_INIT);
               lfsr_d  = SEED;
            end
         end

         ST_RUN: begin
            if (collide) begin
               // The collision wins over any tick arriving in the same cycle.
               state_d = ST_OVER;
               hit_d   = 1'b1;
            end else if (tick) begin
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (spawn_sel[i]) begin
                     pos_d[i]  = POS_W'(SPAWN_X);
                     type_d[i] = spawn_type;
                     en_d[i]   = 1'b1;
                  end else if (en_q[i]) begin
                     if (pos_q[i] >= speed_px) pos_d[i] = pos_q[i] - speed_px;
                     else                      en_d[i]  = 1'b0;
                  end
               end

               // A due spawn with no free slot leaves the counter climbing,
               // so it stays due until a slot frees up.
               if (|spawn_sel)            gap_d = '0;
               else if (gap_q != 8'hFF)   gap_d = gap_q + 8'd1;

               lfsr_d = {lfsr_fb, lfsr_q[15:1]};

               if (step_q == STEP_W'(SPEED_STEP - 1)) begin
                  step_d = '0;
                  if (speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end

         ST_OVER: begin
            if (start) begin
               state_d = ST_IDLE;
               pos_d   = '0;
               type_d  = '0;
               en_d    = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            pos_d   = '0;
            type_d  = '0;
            en_d    = '0;
         end
      endcase
   end

   // State registers; every output is driven straight from one of these flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the slot arrays are ordinary flops, not a RAM, so they take the async reset too.
         state_q <= ST_IDLE;
         pos_q   <= '0;
         type_q  <= '0;
         en_q    <= '0;
         gap_q   <= '0;
         step_q  <= '0;
         speed_q <= 4'(SPEED_INIT);
         lfsr_q  <= SEED;
         hit_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q <= state_d;
         pos_q   <= pos_d;
         type_q  <= type_d;
         en_q    <= en_d;
         gap_q   <= gap_d;
         step_q  <= step_d;
         speed_q <= speed_d;
         lfsr_q  <= lfsr_d;
         hit_q   <= hit_d;
      end
   end

   assign danger_pos  = pos_q;
   assign danger_type = type_q;
   assign danger_en   = en_q;
   assign game_state  = state_q;
   assign speed       = speed_q;
   assign hit         = hit_q;

endmodule

// File: tb/tb_obstacle_manager.sv
// Self-checking bench for obstacle_manager: random tick/start/dino_h stimulus
// compared every cycle against a behavioural game model.
`timescale 1ns/1ps
module tb_obstacle_manager;

   localparam int NUM_SLOTS  = 3;
   localparam int POS_W      = 10;
   localparam int TYPE_W     = 3;
   localparam int NUM_TYPES  = 5;
   localparam int SPAWN_X    = 640;
   localparam int DINO_X     = 64;
   localparam int DINO_W     = 40;
   localparam int HIT_H      = 48;
   localparam int MIN_GAP    = 40;
   localparam int GAP_MASK   = 15;
   localparam int SPEED_INIT = 4;
   localparam int SPEED_MAX  = 12;
   localparam int SPEED_STEP = 256;
   localparam int SEED       = 'hACE1;
   localparam int LFSR_N     = 16384;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        tick;
   logic                        start;
   logic [POS_W-1:0]            dino_h;
   logic [NUM_SLOTS*POS_W-1:0]  danger_pos;
   logic [NUM_SLOTS*TYPE_W-1:0] danger_type;
   logic [NUM_SLOTS-1:0]        danger_en;
   logic [1:0]                  game_state;
   logic [3:0]                  speed;
   logic                        hit;

   obstacle_manager #(
      .NUM_SLOTS(NUM_SLOTS), .POS_W(POS_W), .TYPE_W(TYPE_W), .NUM_TYPES(NUM_TYPES),
      .SPAWN_X(SPAWN_X), .DINO_X(DINO_X), .DINO_W(DINO_W), .HIT_H(HIT_H),
      .MIN_GAP(MIN_GAP), .GAP_MASK(GAP_MASK), .SPEED_INIT(SPEED_INIT),
      .SPEED_MAX(SPEED_MAX), .SPEED_STEP(SPEED_STEP), .SEED(16'(SEED))
   ) u_dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start), .dino_h(dino_h),
      .danger_pos(danger_pos), .danger_type(danger_type), .danger_en(danger_en),
      .game_state(game_state), .speed(speed), .hit(hit)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: game state kept as plain integers.
   int m_state;                 // 0 idle, 1 run, 2 over
   int m_pos  [NUM_SLOTS];
   int m_type [NUM_SLOTS];
   bit m_en   [NUM_SLOTS];
   int m_gap;                   // ticks since last spawn, saturating at 255
   int m_ticks;                 // ticks taken in the current run
   bit m_hit;
   int lfsr_tab [LFSR_N];       // LFSR value in effect before run tick n

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
   endtask

   // Speed follows directly from how many ticks the run has taken.
   function automatic int exp_speed();
      int s;
      s = SPEED_INIT + m_ticks / SPEED_STEP;
      return (s > SPEED_MAX) ? SPEED_MAX : s;
   endfunction

   task automatic model_clear_slots();
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_pos[i]  = 0;
         m_type[i] = 0;
         m_en[i]   = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_gap   = 0;
      m_ticks = 0;
      m_hit   = 1'b0;
      model_clear_slots();
   endtask

   // Advance the model by one clock edge using the inputs held across it.
   task automatic model_step();
      bit collide;
      bit due;
      int spd;
      int lf;
      int free_slot;
      collide = 1'b0;
      if (m_state == 1 && int'(dino_h) < HIT_H)
         for (int i = 0; i < NUM_SLOTS; i++)
            if (m_en[i] && m_pos[i] + 8 >= DINO_X && m_pos[i] < DINO_X + DINO_W)
               collide = 1'b1;
      m_hit = 1'b0;
      case (m_state)
         0: begin
            model_clear_slots();
            if (start) begin
               m_state = 1;
               m_ticks = 0;
               m_gap   = 0;
            end
         end
         1: begin
            if (collide) begin
               m_state = 2;
               m_hit   = 1'b1;
            end else if (tick) begin
               spd = exp_speed();
               lf  = lfsr_tab[m_ticks];
               free_slot = -1;
               for (int i = 0; i < NUM_SLOTS; i++)
                  if (!m_en[i] && free_slot < 0) free_slot = i;
               due = (m_gap >= MIN_GAP + (lf & 'hFF & GAP_MASK));
               for (int i = 0; i < NUM_SLOTS; i++)
                  if (m_en[i]) begin
                     if (m_pos[i] >= spd) m_pos[i] = m_pos[i] - spd;
                     else                 m_en[i]  = 1'b0;
                  end
               if (due && free_slot >= 0) begin
                  m_pos[free_slot]  = SPAWN_X;
                  m_type[free_slot] = ((lf >> 8) & 'hFF) % NUM_TYPES;
                  m_en[free_slot]   = 1'b1;
                  m_gap = 0;
               end else if (m_gap < 255) begin
                  m_gap = m_gap + 1;
               end
               m_ticks = m_ticks + 1;
            end
         end
         default: begin
            if (start) begin
               m_state = 0;
               model_clear_slots();
            end
         end
      endcase
   endtask

   task automatic compare_all();
      logic [63:0] e_pos;
      logic [63:0] e_type;
      logic [63:0] e_en;
      e_pos  = '0;
      e_type = '0;
      e_en   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         e_pos  = e_pos  | (64'(m_pos[i])  << (i * POS_W));
         e_type = e_type | (64'(m_type[i]) << (i * TYPE_W));
         e_en   = e_en   | (64'(m_en[i])   << i);
      end
      check("game_state", 64'(game_state), 64'(m_state));
      check("danger_en", 64'(danger_en), e_en);
      check("danger_pos", 64'(danger_pos), e_pos);
      check("danger_type", 64'(danger_type), e_type);
      check("speed", 64'(speed), 64'(exp_speed()));
      check("hit", 64'(hit), 64'(m_hit));
   endtask

   // One clock: drive inputs at the falling edge, step the model at the
   // rising edge, compare just after it.
   task automatic cycle(input bit t, input bit s, input int h);
      @(negedge clk);
      tick   = t;
      start  = s;
      dino_h = POS_W'(h);
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1 compare_all();
   endtask

   // Async reset in mid-cycle: outputs must clear before any clock edge.
   task automatic mid_run_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1 compare_all();
      @(posedge clk);
      #1 compare_all();
      #2 rst = 1'b0;
   endtask

   initial begin
      int v;
      int b;
      int h;
      v = SEED;
      for (int n = 0; n < LFSR_N; n++) begin
         lfsr_tab[n] = v;
         b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
         v = (v >> 1) | (b << 15);
      end

      rst    = 1'b1;
      tick   = 1'b0;
      start  = 1'b0;
      dino_h = POS_W'(100);
      model_reset();

      // Reset holds everything regardless of tick/start.
      repeat (3) cycle(1'b1, 1'b1, 0);
      #2 rst = 1'b0;

      // Idle ignores tick.
      repeat (5) cycle(1'b1, 1'b0, 100);

      // Long safe run: spawns, deferral, slot reuse, speed ramp and ceiling.
      cycle(1'b0, 1'b1, 100);
      repeat (2600) cycle(1'b1, 1'b0, 100);

      // Reset with slots active, then replay a run from the seed.
      mid_run_reset();
      repeat (3) cycle(1'b1, 1'b0, 100);
      cycle(1'b0, 1'b1, 100);
      repeat (400) cycle(1'b1, 1'b0, 100);

      // Random play: collisions, frozen game-over, restarts, boundary heights.
      repeat (4000) begin
         case ($urandom_range(0, 5))
            0:       h = 0;
            1:       h = HIT_H - 1;
            2:       h = HIT_H;
            3:       h = int'($urandom_range(0, 1023));
            default: h = 100;
         endcase
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, h);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
